// File: rtl/vram_sketch_writer_pkg.sv
// Shared types for the etch-a-sketch VRAM writer:
// display colours, touch bundle, FSM state encoding.
package vram_sketch_writer_pkg;

    localparam int COORD_W = $clog2(320);
    localparam int OFF_W   = COORD_W + 2;

    typedef logic [15:0] color_t;

    localparam color_t BLACK = 16'h0000;
    localparam color_t WHITE = 16'hFFFF;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } touch_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_PAINT
    } state_t;

endpackage

// File: rtl/vram_sketch_writer_brush_scanner.sv
// Walks a BRUSH x BRUSH square row-major and reports
// signed offsets relative to the brush centre.
module vram_sketch_writer_brush_scanner
    import vram_sketch_writer_pkg::*;
#(
    parameter int BRUSH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    step,
    output logic signed [OFF_W-1:0] off_x,
    output logic signed [OFF_W-1:0] off_y,
    output logic                    last
);

    localparam int R     = (BRUSH - 1) / 2;
    localparam int CNT_W = (BRUSH > 1) ? $clog2(BRUSH) : 1;
    localparam logic [CNT_W-1:0] MAX = CNT_W'(BRUSH - 1);

    logic [CNT_W-1:0] dx_q, dx_d;
    logic [CNT_W-1:0] dy_q, dy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        last = (dx_q == MAX) && (dy_q == MAX);
        if (start) begin
            dx_d = '0;
            dy_d = '0;
        end else if (step) begin
            if (dx_q == MAX) begin
                dx_d = '0;
                dy_d = last ? '0 : dy_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
    end

    assign off_x = OFF_W'(dx_q) - OFF_W'(R);
    assign off_y = OFF_W'(dy_q) - OFF_W'(R);

endmodule

// File: rtl/vram_sketch_writer.sv
// Write-side owner of the sketch VRAM: clears it after reset or on
// request and paints a brush square at each new touch point.
module vram_sketch_writer
    import vram_sketch_writer_pkg::*;
#(
    parameter int     DISPLAY_WIDTH  = 240,
    parameter int     DISPLAY_HEIGHT = 320,
    parameter int     VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int     BRUSH          = 3,
    parameter color_t CLEAR_COLOR    = BLACK
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_req,
    input  logic                      touch_valid,
    input  logic [$clog2(320)-1:0]    touch_x,
    input  logic [$clog2(320)-1:0]    touch_y,
    input  logic [15:0]               pen_color,
    output logic                      busy,
    output logic                      vram_wr_ena,
    output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
    output logic [15:0]               vram_wr_data
);

    localparam int AW = $clog2(VRAM_L);
    localparam logic [AW-1:0] LAST_ADDR = AW'(VRAM_L - 1);

    state_t             state_q, state_d;
    logic [AW-1:0]      clr_cnt_q, clr_cnt_d;
    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    color_t             col_q, col_d;
    logic [COORD_W-1:0] last_x_q, last_x_d;
    logic [COORD_W-1:0] last_y_q, last_y_d;
    logic               last_valid_q, last_valid_d;
    logic               wr_ena_q, wr_ena_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    color_t             wr_data_q, wr_data_d;

    logic                    scan_start;
    logic                    scan_step;
    logic                    scan_last;
    logic signed [OFF_W-1:0] off_x;
    logic signed [OFF_W-1:0] off_y;
    logic signed [OFF_W-1:0] px;
    logic signed [OFF_W-1:0] py;
    logic                    pix_ok;
    logic [AW-1:0]           pix_addr;
    logic                    touch_in_range;
    logic                    touch_repeat;

    vram_sketch_writer_brush_scanner #(
        .BRUSH (BRUSH)
    ) u_scanner (
        .clk   (clk),
        .rst   (rst),
        .start (scan_start),
        .step  (scan_step),
        .off_x (off_x),
        .off_y (off_y),
        .last  (scan_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            clr_cnt_q    <= LAST_ADDR;
            cx_q         <= '0;
            cy_q         <= '0;
            col_q        <= '0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            last_valid_q <= 1'b0;
            wr_ena_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            col_q        <= col_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            last_valid_q <= last_valid_d;
            wr_ena_q     <= wr_ena_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Brush pixel position; may fall off any screen edge.
    assign px = $signed({2'b00, cx_q}) + off_x;
    assign py = $signed({2'b00, cy_q}) + off_y;

    assign pix_ok = !px[OFF_W-1] && !py[OFF_W-1]
                 && (px < $signed(OFF_W'(DISPLAY_WIDTH)))
                 && (py < $signed(OFF_W'(DISPLAY_HEIGHT)));

    assign pix_addr = AW'(py) * AW'(DISPLAY_WIDTH) + AW'(px);

    assign touch_in_range = (touch_x < COORD_W'(DISPLAY_WIDTH))
                         && (touch_y < COORD_W'(DISPLAY_HEIGHT));

    assign touch_repeat = last_valid_q
                       && (touch_x == last_x_q)
                       && (touch_y == last_y_q);

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        col_d        = col_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        last_valid_d = last_valid_q;
        wr_ena_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        scan_start   = 1'b0;
        scan_step    = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                wr_ena_d  = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = CLEAR_COLOR;
                clr_cnt_d = clr_cnt_q - 1'b1;
                if (clr_cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    clr_cnt_d = LAST_ADDR;
                    state_d   = S_CLEAR;
                end else if (touch_valid && touch_in_range
                             && !touch_repeat) begin
                    cx_d         = touch_x;
                    cy_d         = touch_y;
                    col_d        = pen_color;
                    last_x_d     = touch_x;
                    last_y_d     = touch_y;
                    last_valid_d = 1'b1;
                    scan_start   = 1'b1;
                    state_d      = S_PAINT;
                end else if (!touch_valid) begin
                    last_valid_d = 1'b0;
                end
            end
            S_PAINT: begin
                // Abort leaves one idle write slot before the clear.
                if (clear_req) begin
                    clr_cnt_d = LAST_ADDR;
                    state_d   = S_CLEAR;
                end else begin
                    scan_step = 1'b1;
                    if (pix_ok) begin
                        wr_ena_d  = 1'b1;
                        wr_addr_d = pix_addr;
                        wr_data_d = col_q;
                    end
                    if (scan_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign vram_wr_ena  = wr_ena_q;
    assign vram_wr_addr = wr_addr_q;
    assign vram_wr_data = wr_data_q;

endmodule
